// File: rtl/pixel_plotter_pkg.sv
// Shared framebuffer geometry, plotter state encoding and pixel address/merge helpers.
package pixel_plotter_pkg;

  localparam int unsigned FB_ADDR_W = 13;
  localparam int unsigned FB_BYTES  = 8192;
  localparam logic [FB_ADDR_W-1:0] FB_LAST_ADDR = FB_ADDR_W'(FB_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_CLEAR
  } state_t;

  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
    return {y, x[7:3]};
  endfunction

  // MSB of each byte is the leftmost pixel, matching scan-out shift order.
  function automatic logic [2:0] pix_bit(input logic [7:0] x);
    return 3'd7 - x[2:0];
  endfunction

  function automatic logic [7:0] merge_bit(input logic [7:0] old, input logic [2:0] b,
                                           input logic c);
    logic [7:0] m;
    m = 8'd1 << b;
    return (old & ~m) | ({8{c}} & m);
  endfunction

endpackage

// File: rtl/pixel_plotter.sv
// Pixel write consumer: byte read-modify-write into a 1bpp 256x256 framebuffer,
// with a one-byte write-through cache and a full-framebuffer clear command.
module pixel_plotter
  import pixel_plotter_pkg::*;
#(
  parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
  input  logic                 ACLK,
  input  logic                 RST,
  input  logic                 PIX_VALID,
  output logic                 PIX_READY,
  input  logic [7:0]           X_IN,
  input  logic [7:0]           Y_IN,
  input  logic                 COLOR,
  input  logic                 CLR_REQ,
  output logic                 BUSY,
  output logic [FB_ADDR_W-1:0] MEM_ADDR,
  output logic                 MEM_RD,
  input  logic [7:0]           MEM_RDATA,
  output logic                 MEM_WR,
  output logic [7:0]           MEM_WDATA
);

  state_t                 r_state,      w_state;
  logic [FB_ADDR_W-1:0]   r_addr,       w_addr;
  logic [2:0]             r_bit,        w_bit;
  logic                   r_color,      w_color;
  logic                   r_cache_vld,  w_cache_vld;
  logic [FB_ADDR_W-1:0]   r_cache_addr, w_cache_addr;
  logic [7:0]             r_cache_data, w_cache_data;
  logic [FB_ADDR_W-1:0]   r_clr_cnt,    w_clr_cnt;
  logic [FB_ADDR_W-1:0]   r_mem_addr,   w_mem_addr;
  logic                   r_mem_rd,     w_mem_rd;
  logic                   r_mem_wr,     w_mem_wr;
  logic [7:0]             r_mem_wdata,  w_mem_wdata;
  logic                   r_busy,       w_busy;

  logic [FB_ADDR_W-1:0]   w_pix_addr;
  logic [2:0]             w_pix_bit;
  logic                   w_hit;
  logic [7:0]             w_merged;

  assign w_pix_addr = pix_addr(X_IN, Y_IN);
  assign w_pix_bit  = pix_bit(X_IN);
  assign w_hit      = r_cache_vld && (r_cache_addr == w_pix_addr);
  assign PIX_READY  = (r_state == ST_IDLE) && !CLR_REQ && !RST;

  assign BUSY      = r_busy;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_RD    = r_mem_rd;
  assign MEM_WR    = r_mem_wr;
  assign MEM_WDATA = r_mem_wdata;

  always_comb begin
    w_state      = r_state;
    w_addr       = r_addr;
    w_bit        = r_bit;
    w_color      = r_color;
    w_cache_vld  = r_cache_vld;
    w_cache_addr = r_cache_addr;
    w_cache_data = r_cache_data;
    w_clr_cnt    = r_clr_cnt;
    w_mem_addr   = r_mem_addr;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_mem_wdata  = r_mem_wdata;
    w_busy       = 1'b0;
    w_merged     = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (CLR_REQ) begin
          w_state     = ST_CLEAR;
          w_cache_vld = 1'b0;
          w_clr_cnt   = '0;
          w_mem_addr  = '0;
          w_mem_wr    = 1'b1;
          w_mem_wdata = CLEAR_VALUE;
          w_busy      = 1'b1;
        end else if (PIX_VALID) begin
          w_addr     = w_pix_addr;
          w_bit      = w_pix_bit;
          w_color    = COLOR;
          w_mem_addr = w_pix_addr;
          if (w_hit) begin
            // Hit: merge into the cached byte and write straight away.
            w_merged     = merge_bit(r_cache_data, w_pix_bit, COLOR);
            w_cache_data = w_merged;
            w_mem_wr     = 1'b1;
            w_mem_wdata  = w_merged;
            w_state      = ST_WRITE;
          end else begin
            w_mem_rd = 1'b1;
            w_state  = ST_READ;
          end
        end
      end
      ST_READ: begin
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        w_merged     = merge_bit(MEM_RDATA, r_bit, r_color);
        w_cache_vld  = 1'b1;
        w_cache_addr = r_addr;
        w_cache_data = w_merged;
        w_mem_wr     = 1'b1;
        w_mem_wdata  = w_merged;
        w_state      = ST_WRITE;
      end
      ST_WRITE: begin
        w_state = ST_IDLE;
      end
      ST_CLEAR: begin
        // The write for r_clr_cnt is already on the bus; stop after the last address.
        if (r_clr_cnt == FB_LAST_ADDR) begin
          w_state = ST_IDLE;
        end else begin
          w_clr_cnt  = r_clr_cnt + 1'b1;
          w_mem_addr = r_clr_cnt + 1'b1;
          w_mem_wr   = 1'b1;
          w_busy     = 1'b1;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_bit        <= '0;
      r_color      <= 1'b0;
      r_cache_vld  <= 1'b0;
      r_cache_addr <= '0;
      r_cache_data <= '0;
      r_clr_cnt    <= '0;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_addr       <= w_addr;
      r_bit        <= w_bit;
      r_color      <= w_color;
      r_cache_vld  <= w_cache_vld;
      r_cache_addr <= w_cache_addr;
      r_cache_data <= w_cache_data;
      r_clr_cnt    <= w_clr_cnt;
      r_mem_addr   <= w_mem_addr;
      r_mem_rd     <= w_mem_rd;
      r_mem_wr     <= w_mem_wr;
      r_mem_wdata  <= w_mem_wdata;
      r_busy       <= w_busy;
    end
  end

endmodule
